// File: rtl/reg_writeback_pkg.sv
// Shared writeback encodings: result-source selects and writeback FSM states,
// also used by the register-fetch and execute stages.
package reg_writeback_pkg;

  localparam logic [1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] WB_SRC_RSVD = 2'd3;

  typedef enum logic {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_e;

  // A write only reaches the register file if requested and not aimed at r0.
  function automatic logic wb_commit(input logic reg_write, input logic rd_nonzero);
    return reg_write & rd_nonzero;
  endfunction

endpackage

// File: rtl/reg_writeback_bypass.sv
// WbBypass: forwards the value being written this cycle to the fetch-stage
// read operands. Present only when REG_WRITEBACK_BYPASS_EN is defined.
`ifdef REG_WRITEBACK_BYPASS_EN
module WbBypass #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS               = 32
) (
  input  logic                           wrtEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  input  logic [DBITS-1:0]               wrtData,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  input  logic [DBITS-1:0]               rfData1,
  input  logic [DBITS-1:0]               rfData2,
  output logic [DBITS-1:0]               outReg1,
  output logic [DBITS-1:0]               outReg2
);

  // wrtEn is never high for rd=0, so r0 reads are never forwarded.
  assign outReg1 = (wrtEn && (rd == rs1)) ? wrtData : rfData1;
  assign outReg2 = (wrtEn && (rd == rs2)) ? wrtData : rfData2;

endmodule
`endif

// File: rtl/reg_writeback.sv
// Writeback stage: result select, load wait FSM and register-file write port.
// Define REG_WRITEBACK_BYPASS_EN to forward the current write to outReg1/2.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS               = 32
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           exValid,
  input  logic                           exRegWrite,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] exRd,
  input  logic [1:0]                     exSrc,
  input  logic [DBITS-1:0]               aluResult,
  input  logic [DBITS-1:0]               pcPlus4,
  input  logic [DBITS-1:0]               memRdata,
  input  logic                           memRvalid,
  output logic                           stall,
  output logic                           wrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  output logic [DBITS-1:0]               wrtData,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  input  logic [DBITS-1:0]               rfData1,
  input  logic [DBITS-1:0]               rfData2,
  output logic [DBITS-1:0]               outReg1,
  output logic [DBITS-1:0]               outReg2,
  output logic                           dbg_state
);

  wb_state_e                      state_q, state_d;
  logic                           wrt_en_q, wrt_en_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] rd_q, rd_d;
  logic [DBITS-1:0]               wrt_data_q, wrt_data_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] ld_rd_q, ld_rd_d;
  logic                           ld_wr_q, ld_wr_d;

  // Handshake: execute offers an instruction with exValid; it is taken only
  // in IDLE. stall=1 (WAIT_MEM) tells upstream to hold, and exValid is ignored.
  always_comb begin
    state_d    = state_q;
    wrt_en_d   = 1'b0;
    rd_d       = rd_q;
    wrt_data_d = wrt_data_q;
    ld_rd_d    = ld_rd_q;
    ld_wr_d    = ld_wr_q;
    case (state_q)
      WB_IDLE: begin
        if (exValid) begin
          if (exSrc == WB_SRC_MEM) begin
            ld_rd_d = exRd;
            ld_wr_d = exRegWrite;
            state_d = WB_WAIT_MEM;
          end else begin
            rd_d     = exRd;
            wrt_en_d = wb_commit(exRegWrite, exRd != '0);
            case (exSrc)
              WB_SRC_ALU:  wrt_data_d = aluResult;
              WB_SRC_LINK: wrt_data_d = pcPlus4;
              default:     wrt_data_d = '0;
            endcase
          end
        end
      end
      WB_WAIT_MEM: begin
        if (memRvalid) begin
          rd_d       = ld_rd_q;
          wrt_data_d = memRdata;
          wrt_en_d   = wb_commit(ld_wr_q, ld_rd_q != '0);
          state_d    = WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q    <= WB_IDLE;
      wrt_en_q   <= 1'b0;
      rd_q       <= '0;
      wrt_data_q <= '0;
      ld_rd_q    <= '0;
      ld_wr_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrt_en_q   <= wrt_en_d;
      rd_q       <= rd_d;
      wrt_data_q <= wrt_data_d;
      ld_rd_q    <= ld_rd_d;
      ld_wr_q    <= ld_wr_d;
    end
  end

  assign stall     = (state_q == WB_WAIT_MEM);
  assign wrtEn     = wrt_en_q;
  assign rd        = rd_q;
  assign wrtData   = wrt_data_q;
  assign dbg_state = state_q;

`ifdef REG_WRITEBACK_BYPASS_EN
  WbBypass #(
    .REG_INDEX_BIT_WIDTH(REG_INDEX_BIT_WIDTH),
    .DBITS              (DBITS)
  ) u_bypass (
    .wrtEn  (wrt_en_q),
    .rd     (rd_q),
    .wrtData(wrt_data_q),
    .rs1    (rs1),
    .rs2    (rs2),
    .rfData1(rfData1),
    .rfData2(rfData2),
    .outReg1(outReg1),
    .outReg2(outReg2)
  );
`else
  assign outReg1 = rfData1;
  assign outReg2 = rfData2;
  logic unused_rs;
  assign unused_rs = ^{rs1, rs2};
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random
// traffic, checked cycle by cycle against a transaction-level model.
module tb_reg_writeback;

  localparam int IW   = 4;
  localparam int DW   = 32;
  localparam int EW   = 32 + IW + DW;
  localparam int NCYC = 4096;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          res;
  logic          exValid, exRegWrite, memRvalid;
  logic [IW-1:0] exRd, rs1, rs2;
  logic [1:0]    exSrc;
  logic [DW-1:0] aluResult, pcPlus4, memRdata, rfData1, rfData2;
  logic          stall, wrtEn, dbg_state;
  logic [IW-1:0] rd;
  logic [DW-1:0] wrtData, outReg1, outReg2;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  reg_writeback #(.REG_INDEX_BIT_WIDTH(IW), .DBITS(DW)) dut (
    .clk(clk), .res(res), .exValid(exValid), .exRegWrite(exRegWrite),
    .exRd(exRd), .exSrc(exSrc), .aluResult(aluResult), .pcPlus4(pcPlus4),
    .memRdata(memRdata), .memRvalid(memRvalid), .stall(stall), .wrtEn(wrtEn),
    .rd(rd), .wrtData(wrtData), .rs1(rs1), .rs2(rs2), .rfData1(rfData1),
    .rfData2(rfData2), .outReg1(outReg1), .outReg2(outReg2),
    .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  // Expected register-file writes: {cycle, rd, data}.
  logic [EW-1:0] exp_q[$];
  bit            pend;
  logic [IW-1:0] ld_rd;
  bit            ld_wr;
  logic [IW-1:0] m_rd;
  logic [DW-1:0] m_data;
  bit            exp_def  [NCYC];
  bit            exp_stall[NCYC];
  logic [IW-1:0] exp_rd   [NCYC];
  logic [DW-1:0] exp_data [NCYC];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit v, input bit wr, input logic [1:0] src,
                       input logic [IW-1:0] d, input logic [DW-1:0] alu,
                       input logic [DW-1:0] pc, input logic [DW-1:0] mem, input bit mv);
    int unsigned n;
    @(posedge clk);
    #1;
    res = r; exValid = v; exRegWrite = wr; exSrc = src; exRd = d;
    aluResult = alu; pcPlus4 = pc; memRdata = mem; memRvalid = mv;
    // Bias read indices toward the register being written this cycle.
    rs1 = ($urandom_range(1, 0) == 1) ? m_rd : IW'($urandom_range(15, 0));
    rs2 = ($urandom_range(1, 0) == 1) ? m_rd : IW'($urandom_range(15, 0));
    rfData1 = $urandom;
    rfData2 = $urandom;
    n = cyc + 1;
    if (r) begin
      pend = 0; m_rd = '0; m_data = '0;
    end else if (pend) begin
      if (mv) begin
        pend = 0; m_rd = ld_rd; m_data = mem;
        if (ld_wr && ld_rd != 0) exp_q.push_back({n, ld_rd, mem});
      end
    end else if (v) begin
      if (src == 2'd1) begin
        pend = 1; ld_rd = d; ld_wr = wr;
      end else begin
        m_rd   = d;
        m_data = (src == 2'd0) ? alu : (src == 2'd2) ? pc : '0;
        if (wr && d != 0) exp_q.push_back({n, d, m_data});
      end
    end
    if (n < NCYC) begin
      exp_def[n] = 1; exp_stall[n] = pend; exp_rd[n] = m_rd; exp_data[n] = m_data;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'd0, '0, '0, '0, '0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] f;
    bit            hit;
    logic [DW-1:0] e1, e2;
    if (cyc < NCYC && exp_def[cyc]) begin
      hit = 0;
      f   = '0;
      if (exp_q.size() > 0) begin
        f   = exp_q[0];
        hit = (f[EW-1 -: 32] == cyc);
      end
      check("wrtEn", wrtEn, hit);
      check("stall", stall, exp_stall[cyc]);
      check("dbg_state", dbg_state, exp_stall[cyc]);
      check("rd", rd, exp_rd[cyc]);
      check("wrtData", wrtData, exp_data[cyc]);
      e1 = rfData1;
      e2 = rfData2;
`ifdef REG_WRITEBACK_BYPASS_EN
      if (hit && f[DW +: IW] == rs1) e1 = f[DW-1:0];
      if (hit && f[DW +: IW] == rs2) e2 = f[DW-1:0];
`endif
      check("outReg1", outReg1, e1);
      check("outReg2", outReg2, e2);
      if (hit) void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned k;
    res = 1; exValid = 0; exRegWrite = 0; exSrc = '0; exRd = '0;
    aluResult = '0; pcPlus4 = '0; memRdata = '0; memRvalid = 0;
    rs1 = '0; rs2 = '0; rfData1 = '0; rfData2 = '0;
    pend = 0; ld_rd = '0; ld_wr = 0; m_rd = '0; m_data = '0;

    // Reset, then idle with a stray memRvalid that must be ignored.
    drive(1, 0, 0, 2'd0, '0, '0, '0, '0, 0);
    drive(1, 0, 0, 2'd0, '0, '0, '0, '0, 0);
    idle();
    drive(0, 0, 0, 2'd0, '0, '0, '0, 32'h5555_0000, 1);
    idle();

    // ALU write to r5, then LINK write to r0 (suppressed), reserved source.
    drive(0, 1, 1, 2'd0, 4'd5, 32'h1234, 32'h99, '0, 0);
    drive(0, 1, 1, 2'd2, 4'd0, 32'h77, 32'h40, '0, 0);
    drive(0, 1, 1, 2'd3, 4'd6, 32'hABCD, 32'h44, '0, 0);
    drive(0, 1, 0, 2'd0, 4'd8, 32'hCAFE, '0, '0, 0);
    idle();

    // Load to r7 with 3-cycle memory and ALU ops offered while waiting.
    drive(0, 1, 1, 2'd1, 4'd7, '0, '0, '0, 0);
    drive(0, 1, 1, 2'd0, 4'd9, 32'h1111, '0, '0, 0);
    drive(0, 1, 1, 2'd0, 4'd10, 32'h2222, '0, '0, 0);
    drive(0, 1, 1, 2'd0, 4'd11, 32'h3333, '0, 32'hDEAD_BEEF, 1);
    idle();

    // Load accepted with memRvalid in the same cycle: that pulse is ignored.
    drive(0, 1, 1, 2'd1, 4'd4, '0, '0, 32'hBAD0_0000, 1);
    drive(0, 0, 0, 2'd0, '0, '0, '0, 32'h600D_0004, 1);
    idle();

    // Reset while waiting on memory drops the load.
    drive(0, 1, 1, 2'd1, 4'd3, '0, '0, '0, 0);
    idle();
    drive(1, 0, 0, 2'd0, '0, '0, '0, '0, 0);
    drive(0, 0, 0, 2'd0, '0, '0, '0, 32'hFEED_F00D, 1);
    idle();

    // Back-to-back ALU ops, then back-to-back loads with fastest memory.
    drive(0, 1, 1, 2'd0, 4'd1, 32'hA1, '0, '0, 0);
    drive(0, 1, 1, 2'd0, 4'd2, 32'hA2, '0, '0, 0);
    drive(0, 1, 1, 2'd0, 4'd3, 32'hA3, '0, '0, 0);
    drive(0, 1, 1, 2'd1, 4'd12, '0, '0, '0, 0);
    drive(0, 1, 1, 2'd1, 4'd13, '0, '0, 32'h0C0C_0C0C, 1);
    drive(0, 1, 1, 2'd1, 4'd13, '0, '0, '0, 0);
    drive(0, 0, 0, 2'd0, '0, '0, '0, 32'h0D0D_0D0D, 1);
    idle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      k = $urandom_range(99, 0);
      drive(k == 0, $urandom_range(9, 0) < 7, $urandom_range(4, 0) != 0,
            2'($urandom_range(3, 0)), IW'($urandom_range(15, 0)), $urandom, $urandom,
            $urandom, $urandom_range(2, 0) == 0);
    end

    // Drain: release any pending load, then let outstanding writes appear.
    drive(0, 0, 0, 2'd0, '0, '0, '0, 32'h0BAD_CAFE, 1);
    for (int i = 0; i < 4; i++) idle();
    @(negedge clk);
    #1;
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
